// File: rtl/dp_arb2_1_if.sv
// Handshake bundle between two datapath producers, the 2:1 arbiter and the consumer.
// master = producer/consumer side, slave = arbiter side.
interface dp_arb2_1_if #(parameter int WIDTH = 64);
  logic             reqA, ackA;
  logic [WIDTH-1:0] dataA;
  logic             reqB, ackB;
  logic [WIDTH-1:0] dataB;
  logic             sel;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_src;
  logic             out_ready;

  modport master (
    output reqA, dataA, reqB, dataB, out_ready,
    input  ackA, ackB, sel, out_valid, out_data, out_src
  );

  modport slave (
    input  reqA, dataA, reqB, dataB, out_ready,
    output ackA, ackB, sel, out_valid, out_data, out_src
  );
endinterface

// File: rtl/dp_arb2_1.sv
// dp_arb2_1: round-robin arbiter for two requesters in front of a shared 64-bit
// 2:1 selector, with a single registered output stage and valid/ready drain.
// Optional macro ARB_STATS_EN adds saturating grant/contention counters.
module dp_arb2_1 #(
  parameter int WIDTH = 64
) (
  input  logic         clk,
  input  logic         reset,   // synchronous, active low
  dp_arb2_1_if.slave   bus
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]  grantsA,
  output logic [31:0]  grantsB,
  output logic [31:0]  contend
`endif
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state, state_nxt;
  logic             last_grant;   // 0 = A, 1 = B; starts at B so A wins first
  logic             gntA, gntB, sel, can_load, ackA, ackB, acc;
  logic [WIDTH-1:0] out_data_q;
  logic             out_src_q;

  assign can_load = (state == EMPTY) || bus.out_ready;

  // Grant: lone requester wins, contention goes to the one not served last.
  always_comb begin
    gntA = bus.reqA & (~bus.reqB | last_grant);
    gntB = bus.reqB & (~bus.reqA | ~last_grant);
    sel  = gntB ? 1'b1 : (gntA ? 1'b0 : last_grant);
    ackA = reset & can_load & gntA;
    ackB = reset & can_load & gntB;
    acc  = ackA | ackB;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= EMPTY;
    else        state <= state_nxt;
  end

  // Next state: a load always leaves us FULL; otherwise a consumed word empties.
  always_comb begin
    state_nxt = state;
    if (acc)                state_nxt = FULL;
    else if (bus.out_ready) state_nxt = EMPTY;
  end

  // Outputs decoded from state plus the combinational grant.
  always_comb begin
    bus.out_valid = (state == FULL);
    bus.sel       = sel;
    bus.ackA      = ackA;
    bus.ackB      = ackB;
    bus.out_data  = out_data_q;
    bus.out_src   = out_src_q;
  end

  // Output word register and round-robin pointer; both move only on accept.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_data_q <= '0;
      out_src_q  <= 1'b0;
      last_grant <= 1'b1;
    end else if (acc) begin
      out_data_q <= sel ? bus.dataB : bus.dataA;
      out_src_q  <= sel;
      last_grant <= sel;
    end
  end

`ifdef ARB_STATS_EN
  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      grantsA <= '0;
      grantsB <= '0;
      contend <= '0;
    end else begin
      if (ackA && grantsA != 32'hFFFF_FFFF) grantsA <= grantsA + 32'd1;
      if (ackB && grantsB != 32'hFFFF_FFFF) grantsB <= grantsB + 32'd1;
      if (bus.reqA && bus.reqB && can_load && contend != 32'hFFFF_FFFF)
        contend <= contend + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  // Requesters must hold req and data steady until their ack.
  a_reqA_hold: assert property (@(posedge clk) disable iff (!reset)
    (bus.reqA && !bus.ackA) |=> bus.reqA);
  a_reqB_hold: assert property (@(posedge clk) disable iff (!reset)
    (bus.reqB && !bus.ackB) |=> bus.reqB);
  a_dataA_hold: assert property (@(posedge clk) disable iff (!reset)
    (bus.reqA && !bus.ackA) |=> $stable(bus.dataA));
  a_dataB_hold: assert property (@(posedge clk) disable iff (!reset)
    (bus.reqB && !bus.ackB) |=> $stable(bus.dataB));
  a_one_ack: assert property (@(posedge clk) !(bus.ackA && bus.ackB));
`endif

endmodule

// File: tb/tb_dp_arb2_1.sv
// Directed bench for dp_arb2_1: stimulus pushes expected output words into a
// scoreboard queue, a negedge monitor pops them as the consumer takes them.
module tb_dp_arb2_1;
  localparam logic [63:0] DA = 64'hABCDABCDABCDABCD;
  localparam logic [63:0] DB = 64'h0123456789ABCDEF;

  typedef struct packed { logic [63:0] data; logic src; } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb[$];

  dp_arb2_1_if #(.WIDTH(64)) bus();

`ifdef ARB_STATS_EN
  logic [31:0] grantsA, grantsB, contend;
  dp_arb2_1 #(.WIDTH(64)) dut (.clk(clk), .reset(reset), .bus(bus),
    .grantsA(grantsA), .grantsB(grantsB), .contend(contend));
`else
  dp_arb2_1 #(.WIDTH(64)) dut (.clk(clk), .reset(reset), .bus(bus));
`endif

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Scoreboard monitor: every consumed word must match the next expected one.
  always @(negedge clk) begin
    if (reset === 1'b1 && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL mon_unexpected: got word %h with no expected entry", bus.out_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("mon_data", bus.out_data, e.data);
        chk("mon_src", {63'd0, bus.out_src}, {63'd0, e.src});
      end
    end
  end

  initial begin
    reset = 1'b0; bus.reqA = 0; bus.reqB = 0; bus.dataA = '0; bus.dataB = '0;
    bus.out_ready = 0;
    tick(); tick();
    @(negedge clk);
    chk("rst_ackA", {63'd0, bus.ackA}, 64'd0);
    chk("rst_ackB", {63'd0, bus.ackB}, 64'd0);
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("rst_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_data", bus.out_data, 64'd0);
    chk("rst_src", {63'd0, bus.out_src}, 64'd0);
    tick();

    // A only
    bus.reqA = 1; bus.dataA = DA; bus.out_ready = 1;
    @(negedge clk);
    chk("a_only_ack", {63'd0, bus.ackA}, 64'd1);
    chk("a_only_sel", {63'd0, bus.sel}, 64'd0);
    sb.push_back('{DA, 1'b0});
    tick(); bus.reqA = 0;
    @(negedge clk);
    chk("a_only_valid", {63'd0, bus.out_valid}, 64'd1);
    chk("a_only_data", bus.out_data, DA);
    tick();

    // Single B word drains to empty
    bus.reqB = 1; bus.dataB = DB;
    @(negedge clk);
    chk("drain_ackB", {63'd0, bus.ackB}, 64'd1);
    chk("drain_sel", {63'd0, bus.sel}, 64'd1);
    sb.push_back('{DB, 1'b1});
    tick(); bus.reqB = 0;
    @(negedge clk);
    chk("drain_valid1", {63'd0, bus.out_valid}, 64'd1);
    tick();
    @(negedge clk);
    chk("drain_valid0", {63'd0, bus.out_valid}, 64'd0);
    tick();

    // Contention: A, B, A, B (B was served last so A goes first)
    bus.reqA = 1; bus.reqB = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rr_sel", {63'd0, bus.sel}, 64'(i % 2));
      chk("rr_ackA", {63'd0, bus.ackA}, 64'(i % 2 == 0));
      chk("rr_ackB", {63'd0, bus.ackB}, 64'(i % 2 == 1));
      sb.push_back((i % 2 == 0) ? exp_t'{DA, 1'b0} : exp_t'{DB, 1'b1});
      tick();
    end

    // Backpressure: B word held while A waits
    bus.reqB = 0; bus.out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_ackA", {63'd0, bus.ackA}, 64'd0);
      chk("bp_data", bus.out_data, DB);
      chk("bp_valid", {63'd0, bus.out_valid}, 64'd1);
      tick();
    end
    bus.out_ready = 1;
    @(negedge clk);
    chk("bp_release_ackA", {63'd0, bus.ackA}, 64'd1);
    sb.push_back('{DA, 1'b0});
    tick(); bus.reqA = 0;
    @(negedge clk);
    chk("bp_nogap_valid", {63'd0, bus.out_valid}, 64'd1);
    chk("bp_nogap_data", bus.out_data, DA);
    tick();

    // Reset mid-transfer: load an unconsumed B word, then reset
    bus.out_ready = 0; bus.reqB = 1;
    @(negedge clk);
    chk("mid_load_ackB", {63'd0, bus.ackB}, 64'd1);
    tick(); bus.reqB = 0;
    @(negedge clk);
    chk("mid_full", {63'd0, bus.out_valid}, 64'd1);
    tick();
    reset = 0; bus.reqA = 1; bus.reqB = 1; bus.out_ready = 1;
    @(negedge clk);
    chk("mid_rst_ackA", {63'd0, bus.ackA}, 64'd0);
    chk("mid_rst_ackB", {63'd0, bus.ackB}, 64'd0);
    tick();
    reset = 1;
    @(negedge clk);
    chk("mid_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("mid_data", bus.out_data, 64'd0);
    chk("mid_first_sel", {63'd0, bus.sel}, 64'd0);
    chk("mid_first_ackA", {63'd0, bus.ackA}, 64'd1);
    sb.push_back('{DA, 1'b0});
    tick(); bus.reqA = 0;
    @(negedge clk);
    chk("mid_second_ackB", {63'd0, bus.ackB}, 64'd1);
    sb.push_back('{DB, 1'b1});
    tick(); bus.reqB = 0;
    tick(); tick();

`ifdef ARB_STATS_EN
    reset = 0; tick(); reset = 1; sb.delete();
    bus.reqA = 1; bus.reqB = 1; bus.out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      sb.push_back((i % 2 == 0) ? exp_t'{DA, 1'b0} : exp_t'{DB, 1'b1});
      tick();
    end
    bus.reqA = 0; bus.reqB = 0;
    @(negedge clk);
    chk("st_grantsA", {32'd0, grantsA}, 64'd5);
    chk("st_grantsB", {32'd0, grantsB}, 64'd5);
    chk("st_contend", {32'd0, contend}, 64'd10);
    tick(); tick();
    force dut.grantsA = 32'hFFFF_FFFF;
    tick();
    release dut.grantsA;
    bus.reqA = 1;
    @(negedge clk);
    chk("st_sat_ackA", {63'd0, bus.ackA}, 64'd1);
    sb.push_back('{DA, 1'b0});
    tick(); bus.reqA = 0;
    @(negedge clk);
    chk("st_sat", {32'd0, grantsA}, 64'h0000_0000_FFFF_FFFF);
    tick(); tick();
`endif

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
